// File: rtl/conv_drv_pkg.sv
// Shared state encoding and sizing helpers for the conv stream driver.
package conv_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    STREAM,
    TAIL,
    WAIT,
    HOLD,
    CLEAR
  } state_e;

  localparam int ACT_W = 2;

  // clog2 that never returns 0, so single-entry tables still get a 1-bit index
  function automatic int clog2p(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int patch_w(input int para_x, input int kmax);
    return para_x + kmax - 1;
  endfunction

  function automatic int patch_h(input int para_y, input int kmax);
    return para_y + kmax - 1;
  endfunction

endpackage

// File: rtl/conv_snake_scan.sv
// Kernel-offset walker: visits (ky,kx) in snake order and remembers the index
// of the offset presented on the previous advance, which is the weight to issue.
module conv_snake_scan
  import conv_drv_pkg::*;
#(
  parameter int KSW = 2,
  parameter int KW  = 2,
  parameter int WAW = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic           advance_i,
  input  logic [KSW-1:0] ksize_i,
  output logic [KW-1:0]  ky_o,
  output logic [KW-1:0]  kx_o,
  output logic [WAW-1:0] widx_o,
  output logic           last_o
);

  logic [KW-1:0]  ky_q, kx_q;
  logic [WAW-1:0] widx_q;
  logic           row_end;
  int             kl;

  always_comb begin
    kl      = int'(ksize_i) - 1;
    row_end = ky_q[0] ? (kx_q == '0) : (int'(kx_q) == kl);
    last_o  = row_end && (int'(ky_q) == kl);
  end

  // The last offset is held so the tail cycle still sees the final window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ky_q   <= '0;
      kx_q   <= '0;
      widx_q <= '0;
    end else if (start_i) begin
      ky_q   <= '0;
      kx_q   <= '0;
      widx_q <= '0;
    end else if (advance_i) begin
      widx_q <= WAW'(int'(ky_q) * int'(ksize_i) + int'(kx_q));
      if (!last_o) begin
        if (row_end)      ky_q <= ky_q + KW'(1);
        else if (ky_q[0]) kx_q <= kx_q - KW'(1);
        else              kx_q <= kx_q + KW'(1);
      end
    end
  end

  assign ky_o   = ky_q;
  assign kx_o   = kx_q;
  assign widx_o = widx_q;

endmodule

// File: rtl/conv_stream_driver.sv
// Sequencer for the fp16 ConvParaScale engine: patch/weight store, snake-order window
// streaming, result hand-off. Define CONV_DRV_TIMEOUT_EN to add the WAIT watchdog and err flag.
module conv_stream_driver
  import conv_drv_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int PARA_X     = 3,
  parameter  int PARA_Y     = 4,
  parameter  int KMAX       = 3,
`ifdef CONV_DRV_TIMEOUT_EN
  parameter  int TIMEOUT    = 64,
`endif
  localparam int PW  = patch_w(PARA_X, KMAX),
  localparam int PH  = patch_h(PARA_Y, KMAX),
  localparam int PAW = clog2p(PW * PH),
  localparam int WAW = clog2p(KMAX * KMAX),
  localparam int KSW = clog2p(KMAX + 1),
  localparam int KW  = clog2p(KMAX),
  localparam int TW  = PARA_X * PARA_Y * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  patch_we,
  input  logic [PAW-1:0]        patch_addr,
  input  logic [DATA_WIDTH-1:0] patch_data,
  input  logic                  w_we,
  input  logic [WAW-1:0]        w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  start,
  input  logic [KSW-1:0]        kernel_size,
  input  logic [ACT_W-1:0]      activation,
  output logic                  busy,
  output logic                  conv_rst,
  output logic                  conv_op_type,
  output logic [TW-1:0]         conv_input,
  output logic [DATA_WIDTH-1:0] conv_weight,
  output logic [KSW-1:0]        conv_ksize,
  output logic [ACT_W-1:0]      conv_act,
  input  logic                  result_ready,
  input  logic [TW-1:0]         result_buffer,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TW-1:0]         out_data,
  output logic                  err
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] patch_q [2**PAW];
  logic [DATA_WIDTH-1:0] wgt_q   [2**WAW];
  logic [KSW-1:0]        ksize_q, kclamp;
  logic [ACT_W-1:0]      act_q;
  logic                  out_valid_q;
  logic [TW-1:0]         out_data_q;
  logic                  scan_start, scan_adv, scan_last, capture, tmo;
  logic                  win_en, wgt_en;
  logic [KW-1:0]         ky, kx;
  logic [WAW-1:0]        widx;

  // Stores are writable in every state; a write mid-run only corrupts that run.
  always_ff @(posedge clk) begin
    if (patch_we) patch_q[patch_addr] <= patch_data;
    if (w_we)     wgt_q[w_addr]       <= w_data;
  end

  always_comb begin
    kclamp = kernel_size;
    if (kernel_size == '0 || int'(kernel_size) > KMAX) kclamp = KSW'(1);
  end

  conv_snake_scan #(
    .KSW (KSW),
    .KW  (KW),
    .WAW (WAW)
  ) u_scan (
    .clk_i     (clk),
    .rst_ni    (rst),
    .start_i   (scan_start),
    .advance_i (scan_adv),
    .ksize_i   (ksize_q),
    .ky_o      (ky),
    .kx_o      (kx),
    .widx_o    (widx),
    .last_o    (scan_last)
  );

`ifdef CONV_DRV_TIMEOUT_EN
  localparam int CW = clog2p(TIMEOUT + 1);
  logic [CW-1:0] wcnt_q;
  logic          err_q;

  assign tmo = (state_q == WAIT) && !result_ready && (wcnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= (state_q == WAIT) ? wcnt_q + CW'(1) : '0;
      if (scan_start) err_q <= 1'b0;
      else if (tmo)   err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    scan_start = 1'b0;
    scan_adv   = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        scan_start = 1'b1;
        state_d    = PRIME;
      end
      PRIME, STREAM: begin
        scan_adv = 1'b1;
        if (scan_last)             state_d = TAIL;
        else if (state_q == PRIME) state_d = STREAM;
      end
      TAIL: state_d = WAIT;
      WAIT: begin
        if (result_ready) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (tmo) begin
          state_d = CLEAR;
        end
      end
      HOLD:    if (out_ready) state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ksize_q     <= '0;
      act_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == HOLD);
      if (scan_start) begin
        ksize_q <= kclamp;
        act_q   <= activation;
      end
      if (capture) out_data_q <= result_buffer;
    end
  end

  assign win_en = (state_q == PRIME) || (state_q == STREAM) || (state_q == TAIL);
  assign wgt_en = (state_q == STREAM) || (state_q == TAIL);

  for (genvar y = 0; y < PARA_Y; y++) begin : g_row
    for (genvar x = 0; x < PARA_X; x++) begin : g_col
      logic [PAW-1:0] addr;
      assign addr = PAW'((int'(ky) + y) * PW + int'(kx) + x);
      assign conv_input[(y*PARA_X+x)*DATA_WIDTH +: DATA_WIDTH] = win_en ? patch_q[addr] : '0;
    end
  end

  assign conv_weight  = wgt_en ? wgt_q[widx] : '0;
  assign busy         = (state_q != IDLE);
  assign conv_rst     = !((state_q == IDLE) || (state_q == CLEAR));
  assign conv_op_type = 1'b0;
  assign conv_ksize   = ksize_q;
  assign conv_act     = act_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;

endmodule

// File: tb/tb_conv_stream_driver.sv
// Directed bench for conv_stream_driver: hand-tabulated snake offsets, patch/weight models.
module tb_conv_stream_driver;
  localparam int DW = 16, PX = 3, PY = 4, PW = 5, NP = 30, TW = PX * PY * DW;

  logic          clk = 1'b0, rst = 1'b0;
  logic          patch_we = 0, w_we = 0, start = 0, result_ready = 0, out_ready = 0;
  logic [4:0]    patch_addr = '0;
  logic [3:0]    w_addr = '0;
  logic [DW-1:0] patch_data = '0, w_data = '0;
  logic [1:0]    kernel_size = '0, activation = '0;
  logic [TW-1:0] result_buffer = '0;
  logic          busy, conv_rst, conv_op_type, out_valid, err;
  logic [TW-1:0] conv_input, out_data;
  logic [DW-1:0] conv_weight;
  logic [1:0]    conv_ksize, conv_act;

  logic [DW-1:0] pm [NP];
  logic [DW-1:0] wm [16];
  int sky3 [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
  int skx3 [9] = '{0, 1, 2, 2, 1, 0, 0, 1, 2};
  int sky2 [4] = '{0, 0, 1, 1};
  int skx2 [4] = '{0, 1, 1, 0};
  int checks = 0, errors = 0;

  conv_stream_driver dut (
    .clk(clk), .rst(rst), .patch_we(patch_we), .patch_addr(patch_addr), .patch_data(patch_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .start(start), .kernel_size(kernel_size),
    .activation(activation), .busy(busy), .conv_rst(conv_rst), .conv_op_type(conv_op_type),
    .conv_input(conv_input), .conv_weight(conv_weight), .conv_ksize(conv_ksize),
    .conv_act(conv_act), .result_ready(result_ready), .result_buffer(result_buffer),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] exp_win(input int ky, input int kx);
    logic [TW-1:0] w;
    w = '0;
    for (int y = 0; y < PY; y++)
      for (int x = 0; x < PX; x++)
        w[(y*PX+x)*DW +: DW] = pm[(ky+y)*PW + kx + x];
    return w;
  endfunction

  task automatic get_off(input int k, input int t, output int ky, output int kx);
    ky = 0; kx = 0;
    if (k == 3)      begin ky = sky3[t]; kx = skx3[t]; end
    else if (k == 2) begin ky = sky2[t]; kx = skx2[t]; end
  endtask

  task automatic load_patch(input bit ramp);
    for (int i = 0; i < NP; i++) begin
      @(negedge clk);
      patch_we = 1; patch_addr = 5'(i); patch_data = ramp ? 16'(i) : 16'h3c00;
      pm[i] = patch_data;
    end
    @(negedge clk); patch_we = 0;
  endtask

  task automatic load_w(input logic [DW-1:0] base);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      w_we = 1; w_addr = 4'(i); w_data = base + 16'(i);
      wm[i] = w_data;
    end
    @(negedge clk); w_we = 0;
  endtask

  // One full run: k is requested size, ke the effective size; bp = cycles of backpressure.
  task automatic do_run(input int k, input int ke, input logic [TW-1:0] res, input int bp,
                        input bit pulse);
    int oky, okx, pky, pkx;
    logic [1:0] a;
    a = 2'(k + 1);
    @(negedge clk); start = 1; kernel_size = 2'(k); activation = a;
    @(negedge clk); start = 0; activation = ~a;
    chk("prime_busy", busy, 1);
    chk("prime_crst", conv_rst, 1);
    chk("prime_ksize", conv_ksize, ke);
    get_off(ke, 0, oky, okx);
    chk("win_t0", conv_input, exp_win(oky, okx));
    chk("wt_t0", conv_weight, 0);
    if (pulse) begin result_ready = 1; result_buffer = ~res; end
    for (int t = 1; t < ke * ke; t++) begin
      pky = oky; pkx = okx;
      if (pulse && t == 2) begin start = 1; kernel_size = 2'd1; end
      @(negedge clk); start = 0; kernel_size = 2'(k); result_ready = 0;
      get_off(ke, t, oky, okx);
      chk($sformatf("win_t%0d", t), conv_input, exp_win(oky, okx));
      chk($sformatf("wt_t%0d", t), conv_weight, wm[pky*ke+pkx]);
      if (ke == 3 && t == 3) chk("win3_e00", conv_input[DW-1:0], 7);
    end
    @(negedge clk); result_ready = 0;
    chk("tail_wt", conv_weight, wm[oky*ke+okx]);
    chk("tail_win", conv_input, exp_win(oky, okx));
    @(negedge clk);
    chk("wait_crst", conv_rst, 1);
    chk("wait_vld", out_valid, 0);
    chk("wait_act", conv_act, a);
    chk("wait_ksize", conv_ksize, ke);
    result_ready = 1; result_buffer = res;
    @(negedge clk);
    result_ready = 0; result_buffer = ~res;
    chk("hold_vld", out_valid, 1);
    chk("hold_data", out_data, res);
    if (pulse) start = 1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk); start = 0;
      chk($sformatf("bp%0d_vld", i), out_valid, 1);
      chk($sformatf("bp%0d_data", i), out_data, res);
    end
    out_ready = 1;
    @(negedge clk); out_ready = 0; start = 0;
    chk("clr_crst", conv_rst, 0);
    chk("clr_vld", out_valid, 0);
    chk("clr_busy", busy, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_crst", conv_rst, 0);
    chk("err", err, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_crst", conv_rst, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_win", conv_input, 0);
    chk("rst_wt", conv_weight, 0);
    chk("rst_op", conv_op_type, 0);
    rst = 1;

    load_patch(0); load_w(16'h4000);
    do_run(1, 1, {6{32'hA5A5_0001}}, 0, 0);
    load_patch(1); load_w(16'h1000);
    do_run(3, 3, {6{32'h1234_5678}}, 0, 0);
    do_run(2, 2, {6{32'hCAFE_0002}}, 5, 0);
    do_run(3, 3, {6{32'h0BAD_F00D}}, 1, 1);
    do_run(0, 1, {6{32'h0000_0FF1}}, 0, 0);

    // async reset in the middle of streaming
    @(negedge clk); start = 1; kernel_size = 2'd3;
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    rst = 0; #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_crst", conv_rst, 0);
    chk("mrst_win", conv_input, 0);
    chk("mrst_wt", conv_weight, 0);
    chk("mrst_ksize", conv_ksize, 0);
    chk("mrst_data", out_data, 0);
    @(negedge clk); rst = 1;
    load_patch(1); load_w(16'h2000);
    do_run(2, 2, {6{32'h7777_0005}}, 0, 0);

`ifdef CONV_DRV_TIMEOUT_EN
    @(negedge clk); start = 1; kernel_size = 2'd1;
    @(negedge clk); start = 0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 0 || i == 63) begin
        chk($sformatf("to_wait%0d", i), conv_rst, 1);
        chk($sformatf("to_err%0d", i), err, 0);
      end
    end
    @(negedge clk);
    chk("to_clr_crst", conv_rst, 0);
    chk("to_clr_vld", out_valid, 0);
    chk("to_clr_err", err, 1);
    @(negedge clk);
    chk("to_idle", busy, 0);
    start = 1;
    @(negedge clk); start = 0;
    chk("to_errclr", err, 0);
    repeat (70) @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
